// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-command bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 19
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              d_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory between fetch and data ports
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 19,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t            r_state,     w_state_nxt;
    owner_t            r_owner,     w_owner_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic [ST_W-1:0]   r_starve,    w_starve_nxt;
    logic              r_mem_en,    w_mem_en_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;
    logic              r_if_ready,  w_if_ready_nxt;
    logic              r_d_ready,   w_d_ready_nxt;

    logic              w_grant_d;
    logic              w_grant_if;

    // Data normally wins a tie; fetch wins once it has been passed over STARVE_LIMIT times.
    assign w_grant_d  = bus.d_req & (~bus.if_req | (r_starve != ST_MAX));
    assign w_grant_if = bus.if_req & ~w_grant_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_IF;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
            r_starve    <= w_starve_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_d_ready   <= w_d_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_cnt_nxt       = r_cnt;
        w_starve_nxt    = r_starve;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_if_ready_nxt  = 1'b0;
        w_d_ready_nxt   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt     = S_BUSY;
                    w_owner_nxt     = OWN_D;
                    w_cnt_nxt       = '0;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = bus.d_we;
                    w_mem_addr_nxt  = bus.d_addr;
                    w_mem_wdata_nxt = bus.d_wdata;
                    if (bus.if_req) begin
                        if (r_starve != ST_MAX) w_starve_nxt = r_starve + ST_W'(1);
                    end else begin
                        w_starve_nxt = '0;
                    end
                end else if (w_grant_if) begin
                    w_state_nxt     = S_BUSY;
                    w_owner_nxt     = OWN_IF;
                    w_cnt_nxt       = '0;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = bus.if_addr;
                    w_mem_wdata_nxt = '0;
                    w_starve_nxt    = '0;
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_LAST) begin
                    // Read data is only valid in the final busy cycle, so capture exactly here.
                    if (!r_mem_we) begin
                        if (r_owner == OWN_D) w_d_rdata_nxt  = bus.mem_rdata;
                        else                  w_if_rdata_nxt = bus.mem_rdata;
                    end
                    w_state_nxt    = S_DONE;
                    w_mem_en_nxt   = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_d_ready_nxt  = (r_owner == OWN_D);
                    w_if_ready_nxt = (r_owner == OWN_IF);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.if_stall  = bus.if_req & ~r_if_ready;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_ready   = r_d_ready;
    assign bus.d_stall   = bus.d_req & ~r_d_ready;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 19;
    localparam int L  = 2;
    localparam int SL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1), .STARVE_LIMIT(SL)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));

    // Memory model: read data only valid in the last busy cycle, garbage otherwise.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int bcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt <= 0;
        else if (bus.mem_en) bcnt <= bcnt + 1;
        else bcnt <= 0;
    end
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[12'h010] <= 19'h2ABCD;
            mem[12'h020] <= 19'h01234;
            mem[12'h0FF] <= 19'h00000;
        end else if (bus.mem_en && bus.mem_we && bcnt == L-1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata  = (bus.mem_en && !bus.mem_we && bcnt == L-1) ? mem[bus.mem_addr] : 19'h7FFFF;
    assign bus1.mem_rdata = bus1.mem_en ? ({7'b0, bus1.mem_addr} ^ 19'h15A5A) : 19'h0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          ifr, dr, dwe;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] wd;
        logic          exp_d, exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_ifrd, exp_drd;
    } vec_t;
    vec_t vt [7];

    int exp_order [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 12'h010, 12'h000, 19'h00000, 1'b0, 1'b0, 12'h010, 19'h2ABCD, 19'h00000};
        vt[1] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h020, 19'h00000, 1'b1, 1'b0, 12'h020, 19'h2ABCD, 19'h01234};
        vt[2] = '{1'b0, 1'b1, 1'b1, 12'h000, 12'h0FF, 19'h12345, 1'b1, 1'b1, 12'h0FF, 19'h2ABCD, 19'h01234};
        vt[3] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h0FF, 19'h00000, 1'b1, 1'b0, 12'h0FF, 19'h2ABCD, 19'h12345};
        vt[4] = '{1'b1, 1'b0, 1'b0, 12'h0FF, 12'h000, 19'h00000, 1'b0, 1'b0, 12'h0FF, 19'h12345, 19'h12345};
        vt[5] = '{1'b1, 1'b1, 1'b0, 12'h020, 12'h010, 19'h00000, 1'b1, 1'b0, 12'h010, 19'h12345, 19'h2ABCD};
        vt[6] = '{1'b0, 1'b1, 1'b1, 12'h000, 12'h020, 19'h00007, 1'b1, 1'b1, 12'h020, 19'h12345, 19'h2ABCD};

        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;

        step(); step();
        chk("rst_mem_en",   32'(bus.mem_en),   0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_ready",    32'({bus.if_ready, bus.d_ready}), 0);
        chk("rst_rdata",    32'(bus.if_rdata | bus.d_rdata), 0);
        rst_n = 1'b1;
        step();

        foreach (vt[i]) begin
            bus.if_req = vt[i].ifr; bus.if_addr = vt[i].ia;
            bus.d_req = vt[i].dr; bus.d_we = vt[i].dwe; bus.d_addr = vt[i].da; bus.d_wdata = vt[i].wd;
            #1;
            if (vt[i].ifr) chk($sformatf("v%0d_if_stall", i), 32'(bus.if_stall), 1);
            if (vt[i].dr)  chk($sformatf("v%0d_d_stall", i),  32'(bus.d_stall), 1);
            for (int k = 1; k <= L; k++) begin
                step();
                chk($sformatf("v%0d_busy%0d_en", i, k),   32'(bus.mem_en),   1);
                chk($sformatf("v%0d_busy%0d_addr", i, k), 32'(bus.mem_addr), 32'(vt[i].exp_addr));
                chk($sformatf("v%0d_busy%0d_we", i, k),   32'(bus.mem_we),   32'(vt[i].exp_we));
            end
            step();
            chk($sformatf("v%0d_d_ready", i),  32'(bus.d_ready),  32'(vt[i].exp_d));
            chk($sformatf("v%0d_if_ready", i), 32'(bus.if_ready), 32'(!vt[i].exp_d));
            chk($sformatf("v%0d_mem_en_done", i), 32'(bus.mem_en), 0);
            chk($sformatf("v%0d_if_rdata", i), 32'(bus.if_rdata), 32'(vt[i].exp_ifrd));
            chk($sformatf("v%0d_d_rdata", i),  32'(bus.d_rdata),  32'(vt[i].exp_drd));
            if (vt[i].exp_d) chk($sformatf("v%0d_d_stall_done", i), 32'(bus.d_stall), 0);
            else             chk($sformatf("v%0d_if_stall_done", i), 32'(bus.if_stall), 0);
            bus.if_req = 0; bus.d_req = 0; bus.d_we = 0;
            step();
            chk($sformatf("v%0d_idle_ready", i), 32'({bus.if_ready, bus.d_ready}), 0);
        end

        // Simultaneous requests: data first, fetch follows once data drops.
        bus.if_req = 1; bus.if_addr = 12'h010; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 12'h0FF;
        step(); step(); step();
        chk("sim_d_ready_t3",  32'(bus.d_ready),  1);
        chk("sim_d_rdata",     32'(bus.d_rdata),  32'h12345);
        chk("sim_if_stall_t3", 32'(bus.if_stall), 1);
        bus.d_req = 0;
        step();
        chk("sim_t4_idle", 32'({bus.mem_en, bus.if_ready}), 0);
        step();
        chk("sim_t5_addr", 32'(bus.mem_addr), 32'h010);
        step(); step();
        chk("sim_if_ready_t7", 32'(bus.if_ready), 1);
        chk("sim_if_rdata",    32'(bus.if_rdata), 32'h2ABCD);
        chk("sim_if_stall_t7", 32'(bus.if_stall), 0);
        bus.if_req = 0;
        step();

        // Both held continuously: D,D,D,F,D,D,D,F at one grant per L+2 cycles.
        begin
            int j = 0;
            bus.if_req = 1; bus.if_addr = 12'h0FF; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 12'h020;
            for (int cyc = 1; cyc <= 40 && j < 8; cyc++) begin
                step();
                if (bus.d_ready || bus.if_ready) begin
                    chk($sformatf("starve_g%0d_owner", j), 32'(bus.d_ready), 32'(exp_order[j]));
                    chk($sformatf("starve_g%0d_cycle", j), 32'(cyc), 32'(3 + (L + 2) * j));
                    if (bus.d_ready) chk($sformatf("starve_g%0d_drd", j), 32'(bus.d_rdata), 32'h00007);
                    else             chk($sformatf("starve_g%0d_ifrd", j), 32'(bus.if_rdata), 32'h12345);
                    j++;
                end
            end
            chk("starve_grant_count", 32'(j), 8);
            bus.if_req = 0; bus.d_req = 0;
            step();
        end

        // Reset in the second busy cycle aborts; held fetch restarts cleanly.
        bus.if_req = 1; bus.if_addr = 12'h010;
        step(); step();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_mem_en",   32'(bus.mem_en),   0);
        chk("arst_mem_addr", 32'(bus.mem_addr), 0);
        chk("arst_if_rdata", 32'(bus.if_rdata), 0);
        chk("arst_d_rdata",  32'(bus.d_rdata),  0);
        chk("arst_if_stall", 32'(bus.if_stall), 1);
        #1 rst_n = 1'b1;
        step();
        chk("arst_busy1_en", 32'(bus.mem_en), 1);
        step();
        chk("arst_busy2_ready", 32'(bus.if_ready), 0);
        step();
        chk("arst_if_ready",   32'(bus.if_ready), 1);
        chk("arst_if_rdata_2", 32'(bus.if_rdata), 32'h2ABCD);
        bus.if_req = 0;
        step();

        // LATENCY=1: single busy cycle, ready at t2, period 3.
        bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 12'h005;
        step();
        chk("l1_t1_en",   32'(bus1.mem_en),   1);
        chk("l1_t1_addr", 32'(bus1.mem_addr), 32'h005);
        step();
        chk("l1_t2_ready", 32'(bus1.d_ready), 1);
        chk("l1_t2_rdata", 32'(bus1.d_rdata), 32'h15A5F);
        step();
        chk("l1_t3_idle", 32'({bus1.d_ready, bus1.mem_en}), 0);
        step();
        chk("l1_t4_en", 32'(bus1.mem_en), 1);
        step();
        chk("l1_t5_ready", 32'(bus1.d_ready), 1);
        bus1.d_req = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-port, fixed-latency memory between the pipeline's instruction-fetch (IF) port and the MEM-stage data port. It serialises accesses with a request/ready handshake, gives data priority with a bounded-starvation guarantee for fetch, and exports stall signals for the hazard unit to drive `pc_writebar` and `IF_ID_loadbar`.

## Interface
- `ADDR_W`, 12, address width
- `DATA_W`, 19, data word width (matches instruction width)
- `LATENCY`, 2, memory cycles per access (≥1)
- `STARVE_LIMIT`, 3, max consecutive data grants while fetch waits (≥1)

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `if_req` in 1: fetch read request, held until `if_ready`
- `if_addr` in ADDR_W: fetch address, stable while `if_req`
- `if_rdata` out DATA_W: registered fetch data
- `if_ready` out 1: one-cycle completion pulse for fetch
- `if_stall` out 1: `if_req & ~if_ready` (combinational)
- `d_req` in 1: data request, held until `d_ready`
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in ADDR_W, `d_wdata` in DATA_W: stable while `d_req`
- `d_rdata` out DATA_W: registered read data
- `d_ready` out 1: one-cycle completion pulse for data
- `d_stall` out 1: `d_req & ~d_ready` (combinational)
- `mem_en`, `mem_we` out 1; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W: memory command, all registered
- `mem_rdata` in DATA_W: valid in last BUSY cycle of a read

## Operation
- States: IDLE, BUSY, DONE. Internal: `owner` (IF/D), `cnt` (0..LATENCY-1), `starve` (0..STARVE_LIMIT).
- IDLE: no request → stay. Request present → pick winner, latch address/we/wdata into mem command regs, `cnt`←0, → BUSY.
- Arbitration: only one requester → it wins. Both: data wins unless `starve == STARVE_LIMIT`, then fetch wins.
- `starve`: data grant while `if_req`=1 → +1 (saturating); fetch grant → 0; data grant with `if_req`=0 → 0.
- BUSY: `mem_en`=1, command stable. `cnt` increments; at `cnt == LATENCY-1` on read, capture `mem_rdata` into owner's rdata reg; → DONE. Writes leave both rdata regs unchanged.
- DONE: `mem_en`=0, owner's ready=1 for exactly this cycle; requests ignored; → IDLE.
- Fetch never writes; `mem_we` = `d_we` only for data grants, else 0.
- Request dropped mid-access: access still completes, ready still pulses; no retraction.
- rdata registers hold last captured value until next capture by same port.

## Timing
- Reset (async assert, any state): state IDLE, `mem_en`/`mem_we`=0, `mem_addr`/`mem_wdata`=0, `if_ready`/`d_ready`=0, `if_rdata`/`d_rdata`=0, `cnt`/`starve`=0. In-flight access aborted, not replayed; held requests re-arbitrate from IDLE after release.
- Request sampled in IDLE cycle t → BUSY t+1..t+LATENCY → ready at t+LATENCY+1 → IDLE t+LATENCY+2.
- Request-to-ready latency: LATENCY+1 cycles. Back-to-back throughput: one access per LATENCY+2 cycles.
- Stall outputs high from request assertion through the cycle before ready; low in ready cycle.
- Requester may deassert or change request the edge after its ready; a still-high request in the following IDLE is a new access.

## Test plan
- Fetch read, LATENCY=2, mem[0x010]=0x2ABCD: `if_req` at t0 → `mem_en` t1–t2 with `mem_addr`=0x010, `if_ready` t3, `if_rdata`=0x2ABCD, `if_stall` high t0–t2.
- Simultaneous `if_req`/`d_req` read in IDLE, `starve`=0 → data granted first, `d_ready` t3; fetch granted t4, `if_ready` t7.
- Both requests held continuously, STARVE_LIMIT=3 → grant order D,D,D,F,D,D,D,F; `starve` returns to 0 after each F.
- Data write 0x12345 to 0x0FF then read 0x0FF → write cycle `mem_we`=1, `d_rdata` unchanged at write ready; read returns 0x12345.
- `reset` asserted low in second BUSY cycle → all outputs zero immediately; after release with `if_req` held, fresh access starts, `if_ready` LATENCY+1 cycles after first IDLE.
- LATENCY=1 build: single-cycle BUSY, ready at t2, back-to-back period 3 cycles.
